systolic_skew_feeder: RTL and testbench

- Operand transmitter that drives one edge (row-A or column-B side) of the pe systolic array.
- Accepts one lane-wide word per k-step over a valid/ready stream and emits it diagonally skewed: lane i is delayed by i enabled cycles.
- Generates the array's shared enable and per-tile accumulator clear, then flushes zeros until the last partial sum has settled.
- Signals tile completion. Two instances, A side and B side, fed in lockstep, feed an N x N array.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 27 ++
 rtl/systolic_skew_feeder.sv | 108 ++++++++++
 tb/tb_systolic_skew_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Constants and types shared by the systolic array top, the operand feeders
// and the result collector.
package systolic_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 2;
  localparam int PE_HOP_LAT = 2;
  localparam int PE_ACC_LAT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

  // Output register + lane skew + operand travel across the array + accumulate.
  function automatic int drain_cycles(input int n);
    return 1 + (n - 1) + PE_HOP_LAT * (n - 1) + PE_ACC_LAT;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift register of fixed depth; one instance per feeder lane.
module skew_delay_line #(
  parameter int depth = 1,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [depth-1:0][width-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int s = 1; s < depth; s++) sr[s] <= sr[s-1];
    end
  end

  assign q = sr[depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the pe systolic array: accepts one k-step per handshake and
// emits it diagonally skewed, then drains zeros and flags tile completion.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int lanes      = LANES,
  parameter int max_k      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [lanes*data_width-1:0] in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [lanes*data_width-1:0] pe_a,
  output logic                        pe_en,
  output logic                        pe_clr,
  output logic                        busy,
  output logic                        tile_done,
  output logic                        err_overflow
);

  localparam int DRAIN = drain_cycles(lanes);
  localparam int KW    = $clog2(max_k + 1);
  localparam int FW    = $clog2(DRAIN + 1);

  feeder_state_e state, state_nxt;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] fl_cnt;
  logic          k_full;

  logic [lanes-1:0][data_width-1:0] lane_in, lane_q;

  assign k_full = (k_cnt == KW'(max_k - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pe_en     = 1'b0;
    pe_clr    = 1'b0;
    tile_done = 1'b0;
    case (state)
      IDLE:   if (in_valid) state_nxt = CLEAR;
      CLEAR: begin
        pe_clr    = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        pe_en    = in_valid;
        if (in_valid && (in_last || k_full)) state_nxt = FLUSH;
      end
      FLUSH: begin
        pe_en = 1'b1;
        if (fl_cnt == FW'(DRAIN - 1)) state_nxt = DONE;
      end
      DONE: begin
        tile_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      k_cnt        <= '0;
      fl_cnt       <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        k_cnt        <= '0;
        fl_cnt       <= '0;
        err_overflow <= 1'b0;
      end
      if (state == STREAM && in_valid) begin
        k_cnt <= k_cnt + KW'(1);
        if (!in_last && k_full) err_overflow <= 1'b1;
      end
      if (state == FLUSH) fl_cnt <= fl_cnt + FW'(1);
    end
  end

  // Outside STREAM the lanes are fed zeros so the array drains cleanly.
  assign lane_in = (state == STREAM) ? in_data : '0;

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    skew_delay_line #(
      .depth(i + 1),
      .width(data_width)
    ) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (pe_clr),
      .en   (pe_en),
      .d    (lane_in[i]),
      .q    (lane_q[i])
    );
  end

  assign pe_a = lane_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// A-side and B-side feeders driven in lockstep; outputs are checked cycle by
// cycle and the skewed streams are folded through an ideal 2x2 array.
module tb_systolic_skew_feeder;

  localparam int DRAIN = 8;
  localparam int MAXK  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_da = '0, in_db = '0;
  logic [15:0] pa, pb;
  logic        rdy_a, en_a, clr_a, busy_a, done_a, err_a;
  logic        rdy_b, en_b, clr_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  systolic_skew_feeder dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_da), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy_a), .pe_a(pa), .pe_en(en_a), .pe_clr(clr_a), .busy(busy_a),
    .tile_done(done_a), .err_overflow(err_a));

  systolic_skew_feeder dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_db), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy_b), .pe_a(pb), .pe_en(en_b), .pe_clr(clr_b), .busy(busy_b),
    .tile_done(done_b), .err_overflow(err_b));

  int checks = 0;
  int errors = 0;

  // Reference: lane inputs accepted since the last clear, and the enabled-cycle
  // count. Word k appears on lane i at enabled cycle k+1+i, zero otherwise.
  int en_cnt  = 0;
  int fed_len = 0;
  bit err_exp = 1'b0;
  int fa[0:63][0:1], fb[0:63][0:1];
  int oa[0:63][0:1], ob[0:63][0:1];
  int wa[0:15][0:1], wb[0:15][0:1];
  int lit_c[0:3] = '{19, 22, 43, 50};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int expv(input bit side, input int i);
    int k;
    k = en_cnt - 1 - i;
    if (k < 0 || k >= fed_len) return 0;
    return side ? fb[k][i] : fa[k][i];
  endfunction

  function automatic logic [15:0] pk(input int l0, input int l1);
    return {8'(l1), 8'(l0)};
  endfunction

  task automatic cycle(input bit r, input bit en, input bit clr, input bit bsy,
                       input bit done, input string tag);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(rdy_a), 32'(r));
    chk({tag, ".en"},    32'(en_a),  32'(en));
    chk({tag, ".clr"},   32'(clr_a), 32'(clr));
    chk({tag, ".busy"},  32'(busy_a), 32'(bsy));
    chk({tag, ".done"},  32'(done_a), 32'(done));
    chk({tag, ".err"},   32'(err_a), 32'(err_exp));
    chk({tag, ".b_en"},  32'(en_b),  32'(en));
    chk({tag, ".b_done"}, 32'(done_b), 32'(done));
    chk({tag, ".b_err"}, 32'(err_b), 32'(err_exp));
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".pe_a_A"}, 32'(pa[i*8 +: 8]), 32'(expv(1'b0, i)));
      chk({tag, ".pe_a_B"}, 32'(pb[i*8 +: 8]), 32'(expv(1'b1, i)));
    end
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        oa[en_cnt][i] = int'(pa[i*8 +: 8]);
        ob[en_cnt][i] = int'(pb[i*8 +: 8]);
      end
    end
    @(posedge clk);
    if (en) en_cnt++;
    #1;
  endtask

  // PE(i,j) sees A lane i after j hops and B lane j after i hops.
  task automatic prod_check(input bit lit);
    int obs, exp;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        obs = 0;
        exp = 0;
        for (int t = 0; t < en_cnt; t++)
          if (t >= i && t >= j) obs += oa[t-j][i] * ob[t-i][j];
        for (int k = 0; k < fed_len; k++) exp += fa[k][i] * fb[k][j];
        chk("c_out", 32'(obs), 32'(exp));
        if (lit) chk("c_out_lit", 32'(obs), 32'(lit_c[i*2+j]));
      end
  endtask

  task automatic accept_word(input int k, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    in_da    = pk(wa[k][0], wa[k][1]);
    in_db    = pk(wb[k][0], wb[k][1]);
    for (int i = 0; i < 2; i++) begin
      fa[fed_len][i] = wa[k][i];
      fb[fed_len][i] = wb[k][i];
    end
    fed_len++;
    cycle(1, 1, 0, 1, 0, "accept");
  endtask

  task automatic start_tile(input int n, input bit ovf);
    in_valid = 1'b1;
    in_last  = (n == 1) && !ovf;
    in_da    = pk(wa[0][0], wa[0][1]);
    in_db    = pk(wb[0][0], wb[0][1]);
    cycle(0, 0, 0, 0, 0, "idle");
    cycle(0, 0, 1, 1, 0, "clear");
    en_cnt  = 0;
    fed_len = 0;
    err_exp = 1'b0;
  endtask

  // gap < 0 picks a random 0..2 stall before each word.
  task automatic run_tile(input int n, input bit ovf, input int gap, input bit b2b, input bit lit);
    int g;
    start_tile(n, ovf);
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((k > 0) ? gap : 0);
      for (int s = 0; s < g; s++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_da    = 16'($urandom);
        cycle(1, 0, 0, 1, 0, "gap");
      end
      accept_word(k, (k == n - 1) && !ovf);
      if (ovf && k == MAXK - 1) err_exp = 1'b1;
    end
    in_valid = 1'($urandom_range(0, 1));
    in_last  = 1'b1;
    in_da    = 16'($urandom);
    in_db    = 16'($urandom);
    for (int f = 0; f < DRAIN; f++) cycle(0, 1, 0, 1, 0, "flush");
    in_valid = b2b;
    cycle(0, 0, 0, 1, 1, "done");
    prod_check(lit);
    if (!b2b) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic rand_words(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 2; i++) begin
        wa[k][i] = int'($urandom_range(0, 255));
        wb[k][i] = int'($urandom_range(0, 255));
      end
  endtask

  initial begin
    // Power-on reset
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0, "por");
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, "idle0");

    // Basic skew: lane0 1,3 and lane1 2,4
    rand_words(2);
    wa[0][0] = 1; wa[0][1] = 2; wa[1][0] = 3; wa[1][1] = 4;
    run_tile(2, 1'b0, 0, 1'b0, 1'b0);

    // Same words with a three-cycle stall between them
    run_tile(2, 1'b0, 3, 1'b0, 1'b0);

    // Full system: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    wa[0][0] = 1; wa[0][1] = 3; wa[1][0] = 2; wa[1][1] = 4;
    wb[0][0] = 5; wb[0][1] = 6; wb[1][0] = 7; wb[1][1] = 8;
    run_tile(2, 1'b0, 0, 1'b0, 1'b1);

    // Overflow: max_k words without in_last, then back-to-back tiles
    rand_words(MAXK);
    run_tile(MAXK, 1'b1, -1, 1'b1, 1'b0);
    rand_words(3);
    run_tile(3, 1'b0, -1, 1'b1, 1'b0);
    rand_words(1);
    run_tile(1, 1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of a tile
    rand_words(4);
    start_tile(4, 1'b0);
    accept_word(0, 1'b0);
    accept_word(1, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cycle(1, 0, 0, 1, 0, "pre_rst");
    en_cnt  = 0;
    fed_len = 0;
    err_exp = 1'b0;
    cycle(0, 0, 0, 0, 0, "rst");
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, "post_rst");

    // Random tiles with random stalls
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, MAXK - 1));
      rand_words(n);
      run_tile(n, 1'b0, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    in_valid = 1'b0;
    cycle(0, 0, 0, 0, 0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
